// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - button/tick inputs and datapath control outputs of clock_mode_ctrl
interface clock_mode_ctrl_if;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic       i_btn_set;
  logic       i_tick;
  logic       o_add_sec;
  logic       o_add_min;
  logic       o_add_hr;
  logic       o_sw_clk;
  logic       o_start_stop;
  logic       o_sw_reset;
  logic       o_blank_lo;
  logic       o_blank_hi;
  logic [1:0] o_state;

  modport master (
    output i_btn_mode, i_btn_inc, i_btn_set, i_tick,
    input  o_add_sec, o_add_min, o_add_hr, o_sw_clk, o_start_stop,
    input  o_sw_reset, o_blank_lo, o_blank_hi, o_state
  );

  modport slave (
    input  i_btn_mode, i_btn_inc, i_btn_set, i_tick,
    output o_add_sec, o_add_min, o_add_hr, o_sw_clk, o_start_stop,
    output o_sw_reset, o_blank_lo, o_blank_hi, o_state
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - button debounce, mode FSM, auto-repeat and blink control for the stopwatch/clock datapath
module clock_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 2,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic             clk,
  input  logic             rst,
  clock_mode_ctrl_if.slave bus
);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_SET  = 2;

  typedef enum logic [1:0] {
    CLK_RUN = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SW      = 2'd3
  } state_e;

  logic [2:0]           btn_raw;
  logic [2:0]           sync1_q, sync1_d;
  logic [2:0]           sync2_q, sync2_d;
  logic [2:0]           level_q, level_d;
  logic [2:0]           press_q, press_d;
  logic [2:0][DB_W-1:0] dbc_q, dbc_d;

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic             add_sec_q, add_sec_d;
  logic             add_min_q, add_min_d;
  logic             add_hr_q, add_hr_d;
  logic             sw_reset_q, sw_reset_d;
  logic             phase_q, phase_d;
  logic             rep_armed_q, rep_armed_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0] rep_last;
  logic             editing;
  logic             rep_hold;
  logic             rep_fire;

  assign btn_raw = {bus.i_btn_set, bus.i_btn_inc, bus.i_btn_mode};

  // Debounce: count disagreeing samples, flip the level after DEBOUNCE_CYCLES in a row.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = '0;
    dbc_d   = '0;
    for (int b = 0; b < 3; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (dbc_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[b] = ~level_q[b];
          press_d[b] = ~level_q[b];
        end else begin
          dbc_d[b] = dbc_q[b] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    add_sec_d   = 1'b0;
    add_min_d   = 1'b0;
    add_hr_d    = 1'b0;
    sw_reset_d  = 1'b0;
    phase_d     = phase_q ^ bus.i_tick;
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    editing     = (state_q == SET_HR) || (state_q == SET_MIN);
    rep_hold    = editing && level_q[BTN_INC] && !press_q[BTN_MODE];
    rep_last    = rep_armed_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);

    // A mode press swallows any inc/set press landing in the same cycle.
    if (press_q[BTN_MODE]) begin
      case (state_q)
        CLK_RUN: state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SW;
        default: state_d = CLK_RUN;
      endcase
    end else begin
      case (state_q)
        SET_HR: begin
          add_hr_d = press_q[BTN_INC];
        end
        SET_MIN: begin
          add_min_d = press_q[BTN_INC];
          add_sec_d = press_q[BTN_SET];
        end
        SW: begin
          sw_reset_d = press_q[BTN_SET] && !run_q;
          if (press_q[BTN_INC]) begin
            run_d = ~run_q;
          end
        end
        default: ;
      endcase
    end

    // Auto-repeat: first pulse after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks.
    if (!rep_hold) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (bus.i_tick) begin
      if (rep_cnt_q >= rep_last) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end

    if (rep_fire) begin
      if (state_q == SET_HR) begin
        add_hr_d = 1'b1;
      end else begin
        add_min_d = 1'b1;
      end
    end

    if ((state_d != state_q) && ((state_d == SET_HR) || (state_d == SET_MIN))) begin
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      dbc_q       <= '0;
      state_q     <= CLK_RUN;
      run_q       <= 1'b0;
      add_sec_q   <= 1'b0;
      add_min_q   <= 1'b0;
      add_hr_q    <= 1'b0;
      sw_reset_q  <= 1'b0;
      phase_q     <= 1'b0;
      rep_armed_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      dbc_q       <= dbc_d;
      state_q     <= state_d;
      run_q       <= run_d;
      add_sec_q   <= add_sec_d;
      add_min_q   <= add_min_d;
      add_hr_q    <= add_hr_d;
      sw_reset_q  <= sw_reset_d;
      phase_q     <= phase_d;
      rep_armed_q <= rep_armed_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  assign bus.o_add_sec    = add_sec_q;
  assign bus.o_add_min    = add_min_q;
  assign bus.o_add_hr     = add_hr_q;
  assign bus.o_sw_reset   = sw_reset_q;
  assign bus.o_start_stop = run_q;
  assign bus.o_sw_clk     = (state_q == SW);
  assign bus.o_state      = state_q;
  // Holding inc keeps the edited digits visible.
  assign bus.o_blank_hi   = phase_q && (state_q == SET_HR) && !level_q[BTN_INC];
  assign bus.o_blank_lo   = phase_q && (state_q == SET_MIN) && !level_q[BTN_INC];
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed and randomized checks of clock_mode_ctrl against an event-level model
module tb_clock_mode_ctrl;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n_sec = 0, n_min = 0, n_hr = 0, n_swr = 0;

  clock_mode_ctrl_if bus_if ();

  clock_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (2),
    .REPEAT_PERIOD  (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.o_add_sec === 1'b1) n_sec++;
    if (bus_if.o_add_min === 1'b1) n_min++;
    if (bus_if.o_add_hr === 1'b1) n_hr++;
    if (bus_if.o_sw_reset === 1'b1) n_swr++;
  end

  function automatic logic [9:0] all_outs();
    return {bus_if.o_add_sec, bus_if.o_add_min, bus_if.o_add_hr, bus_if.o_sw_clk,
            bus_if.o_start_stop, bus_if.o_sw_reset, bus_if.o_blank_lo, bus_if.o_blank_hi,
            bus_if.o_state};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit m, input bit i, input bit s, input int hold, input int gap);
    bus_if.i_btn_mode = m;
    bus_if.i_btn_inc  = i;
    bus_if.i_btn_set  = s;
    step(hold);
    bus_if.i_btn_mode = 1'b0;
    bus_if.i_btn_inc  = 1'b0;
    bus_if.i_btn_set  = 1'b0;
    step(gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.i_btn_mode = 1'b0;
    bus_if.i_btn_inc  = 1'b0;
    bus_if.i_btn_set  = 1'b0;
    bus_if.i_tick     = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (all_outs() !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b", all_outs(), 10'd0);
    end
  endtask

  task automatic test_mode_cycle();
    logic [1:0] exp_st;
    do_reset();
    bus_if.i_btn_mode = 1'b1;
    step(LAT - 1);
    checks++;
    if (bus_if.o_state !== 2'd0) begin
      failures++;
      $display("FAIL mode_early: o_state=%0d expected 0", bus_if.o_state);
    end
    step(1);
    checks++;
    if (bus_if.o_state !== 2'd1) begin
      failures++;
      $display("FAIL mode_latency: o_state=%0d expected 1", bus_if.o_state);
    end
    step(10 - LAT);
    bus_if.i_btn_mode = 1'b0;
    step(12);
    for (int k = 2; k <= 4; k++) begin
      press(1'b1, 1'b0, 1'b0, 8, 12);
      exp_st = 2'(k % 4);
      checks++;
      if (bus_if.o_state !== exp_st) begin
        failures++;
        $display("FAIL mode_step%0d: o_state=%0d expected %0d", k, bus_if.o_state, exp_st);
      end
      checks++;
      if (bus_if.o_sw_clk !== (exp_st == 2'd3)) begin
        failures++;
        $display("FAIL sw_clk_step%0d: o_sw_clk=%b expected %b", k, bus_if.o_sw_clk, exp_st == 2'd3);
      end
    end
  endtask

  task automatic test_inc_debounce();
    int base;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 8, 12);
    base = n_hr;
    press(1'b0, 1'b1, 1'b0, 3, 12);
    checks++;
    if (n_hr - base !== 0) begin
      failures++;
      $display("FAIL glitch_hr: pulses=%0d expected 0", n_hr - base);
    end
    bus_if.i_btn_inc = 1'b1;
    step(LAT - 1);
    checks++;
    if (bus_if.o_add_hr !== 1'b0) begin
      failures++;
      $display("FAIL add_hr_early: got %b expected 0", bus_if.o_add_hr);
    end
    step(1);
    checks++;
    if (bus_if.o_add_hr !== 1'b1) begin
      failures++;
      $display("FAIL add_hr_latency: got %b expected 1", bus_if.o_add_hr);
    end
    step(1);
    checks++;
    if (bus_if.o_add_hr !== 1'b0) begin
      failures++;
      $display("FAIL add_hr_width: got %b expected 0", bus_if.o_add_hr);
    end
    bus_if.i_btn_inc = 1'b0;
    step(12);
    checks++;
    if (n_hr - base !== 1) begin
      failures++;
      $display("FAIL add_hr_count: pulses=%0d expected 1", n_hr - base);
    end
  endtask

  task automatic test_repeat();
    int base;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 8, 12);
    press(1'b1, 1'b0, 1'b0, 8, 12);
    base = n_min;
    bus_if.i_btn_inc = 1'b1;
    step(LAT);
    checks++;
    if (bus_if.o_add_min !== 1'b1) begin
      failures++;
      $display("FAIL repeat_press: o_add_min=%b expected 1", bus_if.o_add_min);
    end
    for (int k = 1; k <= 4; k++) begin
      step(18);
      bus_if.i_tick = 1'b1;
      step(1);
      bus_if.i_tick = 1'b0;
      checks++;
      if (bus_if.o_add_min !== (k >= 2)) begin
        failures++;
        $display("FAIL repeat_tick%0d: o_add_min=%b expected %b", k, bus_if.o_add_min, k >= 2);
      end
      checks++;
      if ({bus_if.o_blank_hi, bus_if.o_blank_lo} !== 2'b00) begin
        failures++;
        $display("FAIL repeat_blank%0d: blanks=%b expected 00", k, {bus_if.o_blank_hi, bus_if.o_blank_lo});
      end
    end
    step(2);
    checks++;
    if (n_min - base !== 4) begin
      failures++;
      $display("FAIL repeat_count: pulses=%0d expected 4", n_min - base);
    end
    bus_if.i_btn_inc = 1'b0;
    step(12);
    base = n_min;
    for (int k = 0; k < 2; k++) begin
      step(18);
      bus_if.i_tick = 1'b1;
      step(1);
      bus_if.i_tick = 1'b0;
    end
    step(2);
    checks++;
    if (n_min - base !== 0) begin
      failures++;
      $display("FAIL repeat_release: pulses=%0d expected 0", n_min - base);
    end
  endtask

  task automatic test_blink();
    logic ph;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 8, 12);
    ph = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(5);
      bus_if.i_tick = 1'b1;
      checks++;
      if (bus_if.o_blank_hi !== ph) begin
        failures++;
        $display("FAIL blink_hold%0d: o_blank_hi=%b expected %b", k, bus_if.o_blank_hi, ph);
      end
      step(1);
      bus_if.i_tick = 1'b0;
      ph = ~ph;
      checks++;
      if ({bus_if.o_blank_hi, bus_if.o_blank_lo} !== {ph, 1'b0}) begin
        failures++;
        $display("FAIL blink_hr%0d: blanks=%b expected %b", k, {bus_if.o_blank_hi, bus_if.o_blank_lo}, {ph, 1'b0});
      end
    end
    press(1'b1, 1'b0, 1'b0, 8, 12);
    checks++;
    if ({bus_if.o_blank_hi, bus_if.o_blank_lo} !== 2'b00) begin
      failures++;
      $display("FAIL blink_entry: blanks=%b expected 00", {bus_if.o_blank_hi, bus_if.o_blank_lo});
    end
    bus_if.i_tick = 1'b1;
    step(1);
    bus_if.i_tick = 1'b0;
    checks++;
    if ({bus_if.o_blank_hi, bus_if.o_blank_lo} !== 2'b01) begin
      failures++;
      $display("FAIL blink_min: blanks=%b expected 01", {bus_if.o_blank_hi, bus_if.o_blank_lo});
    end
    press(1'b1, 1'b0, 1'b0, 8, 12);
    checks++;
    if ({bus_if.o_blank_hi, bus_if.o_blank_lo} !== 2'b00) begin
      failures++;
      $display("FAIL blink_sw: blanks=%b expected 00", {bus_if.o_blank_hi, bus_if.o_blank_lo});
    end
  endtask

  task automatic test_stopwatch();
    int base;
    do_reset();
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b0, 8, 12);
    base = n_swr;
    press(1'b0, 1'b1, 1'b0, 8, 12);
    checks++;
    if (bus_if.o_start_stop !== 1'b1) begin
      failures++;
      $display("FAIL sw_start: o_start_stop=%b expected 1", bus_if.o_start_stop);
    end
    press(1'b0, 1'b0, 1'b1, 8, 12);
    checks++;
    if (n_swr - base !== 0) begin
      failures++;
      $display("FAIL sw_reset_running: pulses=%0d expected 0", n_swr - base);
    end
    press(1'b0, 1'b1, 1'b0, 8, 12);
    checks++;
    if (bus_if.o_start_stop !== 1'b0) begin
      failures++;
      $display("FAIL sw_stop: o_start_stop=%b expected 0", bus_if.o_start_stop);
    end
    press(1'b0, 1'b0, 1'b1, 8, 12);
    checks++;
    if (n_swr - base !== 1) begin
      failures++;
      $display("FAIL sw_reset_stopped: pulses=%0d expected 1", n_swr - base);
    end
    press(1'b0, 1'b1, 1'b0, 8, 12);
    press(1'b1, 1'b0, 1'b0, 8, 12);
    checks++;
    if ({bus_if.o_state, bus_if.o_start_stop, bus_if.o_sw_clk} !== 4'b0010) begin
      failures++;
      $display("FAIL sw_retain: state/run/sw_clk=%b expected 0010",
               {bus_if.o_state, bus_if.o_start_stop, bus_if.o_sw_clk});
    end
  endtask

  task automatic test_mode_wins();
    int base_hr, base_min;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 8, 12);
    base_hr  = n_hr;
    base_min = n_min;
    press(1'b1, 1'b1, 1'b0, 8, 12);
    checks++;
    if (bus_if.o_state !== 2'd2) begin
      failures++;
      $display("FAIL mode_wins_state: o_state=%0d expected 2", bus_if.o_state);
    end
    checks++;
    if ((n_hr - base_hr) + (n_min - base_min) !== 0) begin
      failures++;
      $display("FAIL mode_wins_add: pulses=%0d expected 0", (n_hr - base_hr) + (n_min - base_min));
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 8, 12);
    bus_if.i_btn_inc = 1'b1;
    step(9);
    rst = 1'b1;
    step(1);
    checks++;
    if (all_outs() !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid: got %b expected %b", all_outs(), 10'd0);
    end
    rst  = 1'b0;
    base = n_hr + n_min + n_sec;
    step(12);
    checks++;
    if ({bus_if.o_state, 30'(n_hr + n_min + n_sec - base)} !== 32'd0) begin
      failures++;
      $display("FAIL reset_rehold: state=%0d pulses=%0d expected 0 0", bus_if.o_state, n_hr + n_min + n_sec - base);
    end
    bus_if.i_btn_inc = 1'b0;
    step(12);
  endtask

  task automatic test_random();
    int st, run, act, hold, e_hr, e_min, e_sec, e_swr, b_hr, b_min, b_sec, b_swr;
    bit m, i, s;
    do_reset();
    st  = 0;
    run = 0;
    for (int it = 0; it < 40; it++) begin
      act  = $urandom_range(0, 4);
      hold = $urandom_range(6, 12);
      {m, i, s} = 3'b000;
      {e_hr, e_min, e_sec, e_swr} = {32'd0, 32'd0, 32'd0, 32'd0};
      case (act)
        0: m = 1'b1;
        1: i = 1'b1;
        2: s = 1'b1;
        3: {i, s} = 2'b11;
        default: begin
          hold = $urandom_range(1, 3);
          {m, i, s} = 3'(1 << $urandom_range(0, 2));
        end
      endcase
      if (act == 0) begin
        st = (st + 1) % 4;
      end else if (act != 4) begin
        if (st == 1 && i) e_hr = 1;
        if (st == 2 && i) e_min = 1;
        if (st == 2 && s) e_sec = 1;
        if (st == 3 && s && run == 0) e_swr = 1;
        if (st == 3 && i) run = 1 - run;
      end
      b_hr = n_hr; b_min = n_min; b_sec = n_sec; b_swr = n_swr;
      press(m, i, s, hold, 12);
      checks++;
      if ({n_hr - b_hr, n_min - b_min, n_sec - b_sec, n_swr - b_swr} !== {e_hr, e_min, e_sec, e_swr}) begin
        failures++;
        $display("FAIL rand%0d_pulses: hr/min/sec/swr=%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", it,
                 n_hr - b_hr, n_min - b_min, n_sec - b_sec, n_swr - b_swr, e_hr, e_min, e_sec, e_swr);
      end
      checks++;
      if ({bus_if.o_state, bus_if.o_start_stop, bus_if.o_sw_clk} !== {2'(st), 1'(run), st == 3}) begin
        failures++;
        $display("FAIL rand%0d_state: state/run/sw_clk=%0d/%b/%b expected %0d/%0d/%b", it,
                 bus_if.o_state, bus_if.o_start_stop, bus_if.o_sw_clk, st, run, st == 3);
      end
    end
  endtask

  initial begin
    bus_if.i_btn_mode = 1'b0;
    bus_if.i_btn_inc  = 1'b0;
    bus_if.i_btn_set  = 1'b0;
    bus_if.i_tick     = 1'b0;
    test_reset();
    test_mode_cycle();
    test_inc_debounce();
    test_repeat();
    test_blink();
    test_stopwatch();
    test_mode_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

User-interface controller for the stopwatch/clock datapath. It takes three raw push-buttons (mode, inc, set), synchronizes and debounces them, and runs a mode FSM. The FSM drives the datapath's control inputs: the add pulses for seconds, minutes and hours; the display-select level; the stopwatch start/stop level; and the stopwatch reset pulse. It also produces blink-blanking for the digit pair being edited. It sits between the board buttons and the counter/mux instances, and is clocked by the same enable-based clock as the counters.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a button level change (board build sets ~1_000_000).
- REPEAT_DELAY, 2: i_tick pulses with inc held before auto-repeat starts.
- REPEAT_PERIOD, 1: i_tick pulses between auto-repeat pulses.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_btn_mode  in  1  raw mode button, asynchronous, active-high.
- i_btn_inc  in  1  raw increment / start-stop button, asynchronous.
- i_btn_set  in  1  raw set / stopwatch-clear button, asynchronous.
- i_tick  in  1  one-cycle 2 Hz timebase strobe, used for blink and auto-repeat.
- o_add_sec  out  1  one-cycle pulse; clear/advance seconds.
- o_add_min  out  1  one-cycle pulse; advance minutes.
- o_add_hr  out  1  one-cycle pulse; advance hours.
- o_sw_clk  out  1  display select level: 1 = stopwatch shown, 0 = clock shown.
- o_start_stop  out  1  stopwatch run level: 1 = counting.
- o_sw_reset  out  1  one-cycle pulse; clears the stopwatch counters.
- o_blank_lo  out  1  blank the low digit pair (min in clock, sec in stopwatch).
- o_blank_hi  out  1  blank the high digit pair (hr in clock, min in stopwatch).
- o_state  out  2  FSM state: 0 CLK_RUN, 1 SET_HR, 2 SET_MIN, 3 SW.

## Operation
- Per-button input path:
  - 2-flop synchronizer.
  - Debounce counter: counts cycles in which the synchronized sample differs from the debounced level; it clears on any equal sample. When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A press event is the one-cycle rising edge of the debounced level. Releases generate no event.
- FSM transitions on a mode press: CLK_RUN→SET_HR→SET_MIN→SW→CLK_RUN.
- Button actions by state:
  - CLK_RUN: inc and set ignored.
  - SET_HR: inc press → o_add_hr. set ignored.
  - SET_MIN: inc press → o_add_min. set press → o_add_sec.
  - SW: inc press toggles o_start_stop. set press → o_sw_reset only when o_start_stop=0; ignored while running.
- o_sw_clk = 1 exactly in state SW.
- o_start_stop is retained across mode changes: the stopwatch keeps running while the clock is displayed.
- Auto-repeat in SET_HR/SET_MIN only:
  - While inc stays held, count i_tick pulses.
  - At REPEAT_DELAY ticks, issue one add pulse, then one more every REPEAT_PERIOD ticks.
  - Releasing inc or leaving the state clears the repeat counter.
- Blink:
  - A blink-phase flop toggles on each i_tick; it is forced to 0 on entry to SET_HR/SET_MIN.
  - o_blank_hi = phase in SET_HR; o_blank_lo = phase in SET_MIN.
  - Both blanks are 0 while inc is held and in CLK_RUN/SW.
- Simultaneous events:
  - A mode press in the same cycle as an inc/set press: mode wins and the inc/set event is discarded.
  - inc and set pressed in the same cycle: both act per the current state (SET_MIN issues both o_add_min and o_add_sec).
  - In SW, an inc and set press in the same cycle while stopped: o_sw_reset fires and run starts.
- Widths:
  - Debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits.
  - Repeat counter is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) bits and saturates; it never wraps.

## Timing
- Reset (synchronous, rst high at a clk edge):
  - State = CLK_RUN.
  - All outputs 0, including o_start_stop and o_sw_clk.
  - Synchronizers, debounced levels, counters and blink phase are all 0.
- A button held at reset release produces a press event after debounce; it is not suppressed.
- Latency, raw rising edge held stable → action output high: exactly DEBOUNCE_CYCLES+3 cycles (2 sync + DEBOUNCE_CYCLES + 1 registered output).
- All pulse outputs are registered and high for exactly one cycle.
- o_state, o_sw_clk and o_start_stop update in the same cycle the corresponding pulse would appear.
- An auto-repeat pulse appears 1 cycle after the qualifying i_tick.
- A blank output changes 1 cycle after i_tick.
- A bounce shorter than DEBOUNCE_CYCLES samples produces no event and no output change.
- rst asserted mid-press or mid-repeat: everything clears. The button must release and re-press (or re-debounce high) to act again.

## Test plan
- Reset, then mode held 10 cycles with DEBOUNCE_CYCLES=4: o_state=1 at cycle 7 after the raw edge. Three more presses give 2, 3, 0. o_sw_clk=1 only while o_state=3.
- In SET_HR, inc pulse glitch of 3 cycles: no o_add_hr. inc held 8 cycles: exactly one o_add_hr, 7 cycles after the edge.
- In SET_MIN, inc held with i_tick every 20 cycles, REPEAT_DELAY=2, REPEAT_PERIOD=1: o_add_min at press, then one pulse after each tick from the 2nd tick onward. Release stops pulses. The blank outputs stay 0 while held.
- In SW:
  - inc press sets o_start_stop=1.
  - set press while running: no o_sw_reset.
  - inc press → 0; set press → one o_sw_reset pulse.
  - Mode to CLK_RUN with run=1: o_start_stop stays 1.
- Mode and inc raw edges in the same cycle in SET_HR: o_state→2, no o_add_hr.
- rst asserted during a held inc in SET_HR: all outputs 0 next cycle, o_state=0. Continued hold after rst release gives one event but no add pulse, since the state is CLK_RUN.
